// File: rtl/egress_arbiter.sv
// egress_arbiter: round-robin, burst-bounded drain of two show-ahead FIFOs into one
// registered valid/ready egress stream. Define EGRESS_CNT_EN to add per-FIFO pop counters.
module egress_arbiter #(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] out0,
    input  logic [DW-1:0] out1,
    input  logic          fifo0_empty,
    input  logic          fifo1_empty,
    input  logic          dest_ready,
    output logic          pop0,
    output logic          pop1,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic          src_out
`ifdef EGRESS_CNT_EN
    ,
    output logic [15:0]   cnt0,
    output logic [15:0]   cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] BCNT_LAST = 4'(BURST - 1);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          src_q;
    logic          can_load;

    assign can_load = !valid_q || dest_ready;

    // last resets to 1 so FIFO 0 wins the first contention after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo0_empty && !fifo1_empty) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (!fifo0_empty) begin
                    state_d = GRANT0;
                end else if (!fifo1_empty) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                // Yield on an empty head or on the final pop of the burst.
                if (fifo0_empty || (can_load && bcnt_q == BCNT_LAST)) begin
                    last_d  = 1'b0;
                    bcnt_d  = '0;
                    state_d = fifo1_empty ? IDLE : GRANT1;
                end else if (can_load) begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            GRANT1: begin
                if (fifo1_empty || (can_load && bcnt_q == BCNT_LAST)) begin
                    last_d  = 1'b1;
                    bcnt_d  = '0;
                    state_d = fifo0_empty ? IDLE : GRANT0;
                end else if (can_load) begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pops depend only on registered state, empties and the handshake, never on FIFO data.
    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        case (state_q)
            GRANT0:  pop0 = !fifo0_empty && can_load;
            GRANT1:  pop1 = !fifo1_empty && can_load;
            default: begin
                pop0 = 1'b0;
                pop1 = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= 1'b0;
        end else if (pop0) begin
            data_q  <= out0;
            src_q   <= 1'b0;
            valid_q <= 1'b1;
        end else if (pop1) begin
            data_q  <= out1;
            src_q   <= 1'b1;
            valid_q <= 1'b1;
        end else if (dest_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign src_out   = src_q;

`ifdef EGRESS_CNT_EN
    logic [1:0] pop_vec;
    assign pop_vec = {pop1, pop0};

    // Saturating counters so a long soak never wraps back to a plausible small value.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [15:0] cnt_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (pop_vec[gi] && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign cnt0 = g_cnt[0].cnt_q;
    assign cnt1 = g_cnt[1].cnt_q;
`endif

endmodule

// File: tb/tb_egress_arbiter.sv
// Scoreboard bench for egress_arbiter: behavioural show-ahead FIFOs feed the DUT, a monitor
// checks every beat and every stall against hand-ordered expected words.
module tb_egress_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  out0, out1;
    logic        fifo0_empty, fifo1_empty;
    logic        dest_ready;
    logic        pop0, pop1;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        src_out;
`ifdef EGRESS_CNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    always #5 clk = ~clk;

    egress_arbiter #(.DW(8), .BURST(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .out0        (out0),
        .out1        (out1),
        .fifo0_empty (fifo0_empty),
        .fifo1_empty (fifo1_empty),
        .dest_ready  (dest_ready),
        .pop0        (pop0),
        .pop1        (pop1),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .src_out     (src_out)
`ifdef EGRESS_CNT_EN
        ,
        .cnt0        (cnt0),
        .cnt1        (cnt1)
`endif
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         stall_cycles = 0;
    int         pops0_seen = 0;
    int         pops1_seen = 0;
    bit         mon_en = 1'b1;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [8:0] exp_q[$];
    int         beat_cyc[$];
    logic [8:0] mon_e;
    int         t0;

    function automatic void chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each beat, checks hold behaviour on each stall.
    always @(negedge clk) begin
        if (!reset && mon_en && valid_out) begin
            if (dest_ready) begin
                chk("beat_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", int'(data_out), int'(mon_e[7:0]));
                    chk("beat_src", int'(src_out), int'(mon_e[8]));
                    beat_cyc.push_back(cyc);
                    $display("beat cyc=%0d src=%0d data=0x%02h", cyc, src_out, data_out);
                end
            end else begin
                stall_cycles++;
                chk("stall_pop0", int'(pop0), 0);
                chk("stall_pop1", int'(pop1), 0);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q[0];
                    chk("stall_data", int'(data_out), int'(mon_e[7:0]));
                end
            end
        end
    end

    task automatic refresh();
        fifo0_empty = (q0.size() == 0);
        fifo1_empty = (q1.size() == 0);
        out0 = (q0.size() != 0) ? q0[0] : 8'h00;
        out1 = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    // One clock: sample pops mid-cycle, retire popped heads just after the edge.
    task automatic tick();
        logic p0, p1;
        @(negedge clk);
        p0 = pop0;
        p1 = pop1;
        chk("pop_exclusive", int'(p0 & p1), 0);
        @(posedge clk);
        #1;
        if (p0) begin
            pops0_seen++;
            chk("pop0_nonempty", int'(q0.size() != 0), 1);
            if (q0.size() != 0) void'(q0.pop_front());
        end
        if (p1) begin
            pops1_seen++;
            chk("pop1_nonempty", int'(q1.size() != 0), 1);
            if (q1.size() != 0) void'(q1.pop_front());
        end
        refresh();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        refresh();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        beat_cyc.delete();
        pops0_seen = 0;
        pops1_seen = 0;
    endtask

    initial begin
        reset      = 1'b1;
        dest_ready = 1'b1;
        refresh();
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_src", int'(src_out), 0);
        chk("rst_pop0", int'(pop0), 0);
        chk("rst_pop1", int'(pop1), 0);
        @(posedge clk);
        #1;

        // Single source: first word two cycles after non-empty, then one per cycle
        q0.push_back(8'h11); q0.push_back(8'h22); q0.push_back(8'h33);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'h33});
        t0 = cyc;
        refresh();
        drain();
        chk("single_beats", beat_cyc.size(), 3);
        if (beat_cyc.size() >= 3) begin
            chk("first_word_latency", beat_cyc[0] - t0, 2);
            chk("second_word_cycle", beat_cyc[1] - t0, 3);
            chk("third_word_cycle", beat_cyc[2] - t0, 4);
        end

        // Round-robin, 6 words each: A0-A3, B0-B3, A4-A5, B4-B5
        do_reset();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(8'(8'hA0 + i));
            q1.push_back(8'(8'hB0 + i));
        end
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'(8'hA0 + i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'(8'hB0 + i)});
        for (int i = 4; i < 6; i++) exp_q.push_back({1'b0, 8'(8'hA0 + i)});
        for (int i = 4; i < 6; i++) exp_q.push_back({1'b1, 8'(8'hB0 + i)});
        refresh();
        drain();
        chk("rr_beats", beat_cyc.size(), 12);
        if (beat_cyc.size() >= 9) begin
            chk("rr_switch_0to1_gap", beat_cyc[4] - beat_cyc[3], 1);
            chk("rr_switch_1to0_gap", beat_cyc[8] - beat_cyc[7], 1);
        end

        // Backpressure: 3 stalled cycles mid-stream
        beat_cyc.delete();
        stall_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            q0.push_back(8'(8'hC0 + i));
            exp_q.push_back({1'b0, 8'(8'hC0 + i)});
        end
        refresh();
        repeat (3) tick();
        dest_ready = 1'b0;
        repeat (3) tick();
        dest_ready = 1'b1;
        drain();
        chk("stall_cycles", stall_cycles, 3);
        chk("bp_beats", beat_cyc.size(), 6);

        // FIFO 0 empties after 2 words: one detect cycle, then GRANT1
        do_reset();
        q0.push_back(8'hD0); q0.push_back(8'hD1);
        q1.push_back(8'hE0); q1.push_back(8'hE1); q1.push_back(8'hE2);
        exp_q.push_back({1'b0, 8'hD0});
        exp_q.push_back({1'b0, 8'hD1});
        exp_q.push_back({1'b1, 8'hE0});
        exp_q.push_back({1'b1, 8'hE1});
        exp_q.push_back({1'b1, 8'hE2});
        refresh();
        drain();
        chk("empty_beats", beat_cyc.size(), 5);
        if (beat_cyc.size() >= 3) chk("empty_switch_gap", beat_cyc[2] - beat_cyc[1], 2);

        // Asynchronous reset mid-burst with a word held in the output register
        for (int i = 0; i < 6; i++) begin
            q0.push_back(8'(8'h81 + i));
            exp_q.push_back({1'b0, 8'(8'h81 + i)});
        end
        refresh();
        repeat (3) tick();
        chk("pre_reset_valid", int'(valid_out), 1);
        chk("pre_reset_pop0", int'(pop0), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(valid_out), 0);
        chk("async_rst_data", int'(data_out), 0);
        chk("async_rst_pop0", int'(pop0), 0);
        chk("async_rst_pop1", int'(pop1), 0);
        q0.delete();
        q1.delete();
        exp_q.delete();
        refresh();
        @(posedge clk);
        #1 reset = 1'b0;
        beat_cyc.delete();
        q0.push_back(8'hF0);
        q1.push_back(8'h0F);
        exp_q.push_back({1'b0, 8'hF0});
        exp_q.push_back({1'b1, 8'h0F});
        refresh();
        drain();
        chk("post_reset_beats", beat_cyc.size(), 2);

`ifdef EGRESS_CNT_EN
        // Counters: 5 from FIFO 0, 3 from FIFO 1 (order 4xA, 3xB, 1xA)
        do_reset();
        for (int i = 0; i < 5; i++) q0.push_back(8'(8'h50 + i));
        for (int i = 0; i < 3; i++) q1.push_back(8'(8'h60 + i));
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'(8'h50 + i)});
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 8'(8'h60 + i)});
        exp_q.push_back({1'b0, 8'h54});
        refresh();
        drain();
        chk("cnt0_value", int'(cnt0), 5);
        chk("cnt1_value", int'(cnt1), 3);

        // Saturation: 65537 pops from FIFO 0 must leave cnt0 at 16'hFFFF
        do_reset();
        mon_en = 1'b0;
        for (int n = 0; n < 85000 && pops0_seen < 65537; n++) begin
            if (q0.size() < 2) begin
                q0.push_back(8'h5A);
                refresh();
            end
            tick();
            if (pops0_seen == 65534 && q0.size() < 3) begin
                chk("cnt0_fffe", int'(cnt0), 16'hFFFE);
                q0.push_back(8'h5A);
                refresh();
            end
        end
        chk("sat_pops", pops0_seen, 65537);
        chk("cnt0_saturated", int'(cnt0), 16'hFFFF);
        chk("cnt1_untouched", int'(cnt1), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/egress_arbiter.md
# egress_arbiter

Downstream stage of the router. It drains the router's two destination FIFOs (show-ahead heads on `out0`/`out1`, with `fifo0_empty`/`fifo1_empty`) into one registered 8-bit egress stream. Arbitration is round-robin with bounded bursts, and the output follows a valid/ready handshake toward the link transmitter. Optional per-destination word counters support traffic checking.

## Interface
Parameters:
- `DW`, 8: data width. Matches router `out0`/`out1`.
- `BURST`, 4: maximum consecutive pops from one FIFO before yielding. Legal range 1..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high. Clears all state immediately.
- `out0`  in  DW  head word of destination FIFO 0. Valid whenever `fifo0_empty`=0.
- `out1`  in  DW  head word of destination FIFO 1. Valid whenever `fifo1_empty`=0.
- `fifo0_empty`  in  1  FIFO 0 empty.
- `fifo1_empty`  in  1  FIFO 1 empty.
- `dest_ready`  in  1  downstream accepts `data_out` this cycle.
- `pop0`  out  1  combinational pop strobe to FIFO 0.
- `pop1`  out  1  combinational pop strobe to FIFO 1.
- `data_out`  out  DW  registered egress word.
- `valid_out`  out  1  `data_out` holds a word.
- `src_out`  out  1  source FIFO of `data_out` (0/1).
- `cnt0`  out  16  words popped from FIFO 0. Present only with `EGRESS_CNT_EN`.
- `cnt1`  out  16  words popped from FIFO 1. Present only with `EGRESS_CNT_EN`.

## Operation
Terms:
- `can_load = !valid_out || dest_ready`.
- Beat: a cycle with `valid_out && dest_ready`.

FSM has three states: IDLE, GRANT0, GRANT1. Registers:
- `last`, 1 bit: last served FIFO.
- `bcnt`: pops in the current burst.

IDLE:
- No pops.
- Both FIFOs empty: stay in IDLE.
- Exactly one FIFO non-empty: go to that FIFO's GRANT state.
- Both non-empty: go to GRANT(!last).

GRANTx, pop rule:
- `popx = !fifox_empty && can_load`.
- The other pop is always 0. `pop0` and `pop1` are never both high.

GRANTx with a pop:
- Load `data_out <= outx`, `src_out <= x`, `valid_out <= 1`.
- If `bcnt == BURST-1`: set `last <= x`, `bcnt <= 0`, and go to GRANT(!x) if `fifo(!x)_empty`=0, otherwise IDLE.
- Otherwise: `bcnt <= bcnt+1` and stay.

GRANTx with `fifox_empty`=1:
- Set `last <= x`, `bcnt <= 0`.
- Go to GRANT(!x) if that FIFO is non-empty, otherwise IDLE.

GRANTx, FIFO non-empty but `can_load`=0:
- Hold state and `bcnt`. No pop.

Output register without a pop:
- If `dest_ready`: `valid_out <= 0`.
- `data_out` and `src_out` hold their values.

Reset (asynchronous, including mid-burst):
- FSM goes to IDLE. `last` = 1, so FIFO 0 wins the first contention. `bcnt` = 0.
- `valid_out` = 0, `data_out` = 0, `src_out` = 0.
- `pop0`/`pop1` = 0 while reset is high.
- A word held in the output register is discarded.

## Timing
- IDLE to first pop: the FIFO goes non-empty in cycle n. FSM is in GRANTx and pops in cycle n+1. `valid_out` is 1 in cycle n+2.
- Streaming in GRANTx with `dest_ready`=1: one pop and one beat per cycle.
- Burst switch with the other FIFO non-empty: no bubble. The last pop of FIFO x is in cycle m; the first pop of FIFO !x is in cycle m+1.
- Stall: `dest_ready`=0 with `valid_out`=1 forces `pop`=0 in the same cycle. `data_out` is held stable until the beat.
- Pops are combinational from registered state, `fifox_empty`, `valid_out` and `dest_ready`. There is no path from `out0`/`out1` to the pops.

## Configuration
`EGRESS_CNT_EN` defined:
- Adds `cnt0`/`cnt1`.
- Each counter increments by 1 on every cycle its pop is high.
- Counters saturate at 16'hFFFF (no wrap).
- Reset value is 0.

`EGRESS_CNT_EN` undefined:
- The ports and counter logic are absent.
- All other behaviour is identical.

## Test plan
- Reset: assert `reset` mid-burst with `valid_out`=1. Required response: `valid_out`, `data_out`, `pop0`/`pop1` go to 0 without a clock edge. After release, FIFO 0 is served first under contention.
- Single source: FIFO 0 holds 0x11,0x22,0x33, FIFO 1 empty, `dest_ready`=1. Required response: `data_out` shows 0x11,0x22,0x33 on consecutive cycles, first word two cycles after non-empty, `src_out`=0 throughout.
- Round-robin: both FIFOs hold 6 words, `BURST`=4. Required pop order: 4×FIFO0, 4×FIFO1, 2×FIFO0, 2×FIFO1, with no idle cycle between grants.
- Backpressure: drop `dest_ready` for 3 cycles while streaming. Required response: `data_out` stable, no pops during the stall. On resume, no word is lost or duplicated.
- Empty mid-burst: FIFO 0 empties after 2 words while FIFO 1 holds data. Required response: the next cycle switches to GRANT1.
- With `EGRESS_CNT_EN`: pop 5 words from FIFO 0 and 3 from FIFO 1, expect `cnt0`=5 and `cnt1`=3. Preload a counter to 16'hFFFE, pop twice, expect it to hold at 16'hFFFF.
